// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters,
// used by both the receive and transmit blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer interface: received byte, valid/ack handshake and
// the one-clock error pulses.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        output rx_ack
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) line level so reset never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first
// data capture, stop-bit check and a valid/ack output register with overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        sample_en,
    uart_rx_if.master   rx
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    uart_state_t          state_next;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 line_hold;

    logic tick_clear;
    logic tick_inc;
    logic bit_clear;
    logic bit_shift;
    logic stop_good;
    logic stop_bad;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // line_hold blocks a new start after a low stop bit until the line has
    // been seen high again, so a held break yields a single frame error.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs && !line_hold) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_en && tick_cnt == TICK_HALF) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_en && tick_cnt == TICK_LAST && bit_idx == BIT_LAST) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_en && tick_cnt == TICK_LAST) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        tick_clear = 1'b0;
        tick_inc   = 1'b0;
        bit_clear  = 1'b0;
        bit_shift  = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                tick_clear = 1'b1;
                bit_clear  = 1'b1;
            end
            START: begin
                if (sample_en) begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_clear = 1'b1;
                        bit_clear  = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_en) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_clear = 1'b1;
                        bit_shift  = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_en) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_clear = 1'b1;
                        stop_good  = rxs;
                        stop_bad   = !rxs;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
        endcase
    end

    // A completion takes priority over an ack; an ack on the completion edge
    // simply means the old byte was consumed, so it is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt       <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            line_hold      <= 1'b0;
            rx.rx_data     <= '0;
            rx.rx_valid    <= 1'b0;
            rx.frame_err   <= 1'b0;
            rx.overrun_err <= 1'b0;
        end else begin
            if (tick_clear) begin
                tick_cnt <= '0;
            end else if (tick_inc) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end

            if (bit_clear) begin
                bit_idx <= '0;
            end else if (bit_shift) begin
                bit_idx <= bit_idx + BIT_W'(1);
            end

            if (bit_shift) begin
                shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            end

            if (stop_bad) begin
                line_hold <= 1'b1;
            end else if (state == IDLE && rxs) begin
                line_hold <= 1'b0;
            end

            rx.frame_err   <= stop_bad;
            rx.overrun_err <= stop_good && rx.rx_valid && !rx.rx_ack;

            if (stop_good) begin
                rx.rx_data  <= shift_reg;
                rx.rx_valid <= 1'b1;
            end else if (rx.rx_ack && rx.rx_valid) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level model of the valid/ack/error rules.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic sample_en;

    uart_rx_if #(.DATA_BITS(DB)) rx_bus ();

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .sample_en (sample_en),
        .rx        (rx_bus.master)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ferr_seen   = 0;
    int ovr_seen    = 0;
    int div         = 1;
    int div_cnt     = 0;

    logic [DB-1:0] exp_data;
    bit            exp_valid;
    int            exp_ferr;
    int            exp_ovr;
    bit            valid_trace [0:400];

    // Oversample tick every div clocks.
    always @(posedge clk) begin
        #1;
        if (div_cnt >= div - 1) div_cnt = 0;
        else                    div_cnt++;
        sample_en = (div_cnt == 0);
    end

    always @(negedge clk) begin
        if (rx_bus.frame_err === 1'b1)   ferr_seen++;
        if (rx_bus.overrun_err === 1'b1) ovr_seen++;
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_data"},  32'(rx_bus.rx_data), 32'(exp_data));
        check_output({tag, "_valid"}, 32'(rx_bus.rx_valid), 32'(exp_valid));
        check_output({tag, "_ferr"},  32'(ferr_seen), 32'(exp_ferr));
        check_output({tag, "_ovr"},   32'(ovr_seen), 32'(exp_ovr));
    endtask

    // Serialises one frame; ack_at/rst_at are clock offsets from the start
    // bit (negative = never) at which rx_ack or a 2-clock rst are driven.
    task automatic apply_stimulus(input logic [DB-1:0] data, input bit stop_bit,
                                  input int ack_at, input int rst_at);
        int bit_len;
        int total;
        logic [DB+1:0] frame;
        bit_len = OS * div;
        total   = (DB + 2) * bit_len;
        frame   = {stop_bit, data, 1'b0};
        for (int c = 0; c < total; c++) begin
            rxd           = frame[c / bit_len];
            rx_bus.rx_ack = (c == ack_at);
            rst           = (rst_at >= 0 && c >= rst_at && c < rst_at + 2);
            if (c <= 400) valid_trace[c] = rx_bus.rx_valid;
            @(posedge clk);
            #1;
        end
        rxd           = 1'b1;
        rx_bus.rx_ack = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic model_frame(input logic [DB-1:0] data, input bit stop_bit,
                               input bit ack_on_completion);
        if (stop_bit) begin
            if (exp_valid && !ack_on_completion) exp_ovr++;
            exp_data  = data;
            exp_valid = 1'b1;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic consume();
        rx_bus.rx_ack = 1'b1;
        wait_clks(1);
        rx_bus.rx_ack = 1'b0;
        exp_valid = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] rdata;
        bit            rstop;

        rxd           = 1'b1;
        rst           = 1'b1;
        sample_en     = 1'b1;
        rx_bus.rx_ack = 1'b0;
        exp_data      = '0;
        exp_valid     = 1'b0;
        exp_ferr      = 0;
        exp_ovr       = 0;

        wait_clks(4);
        check_output("rst_data",  32'(rx_bus.rx_data), 32'h0);
        check_output("rst_valid", 32'(rx_bus.rx_valid), 32'h0);
        check_output("rst_ferr",  32'(rx_bus.frame_err), 32'h0);
        check_output("rst_ovr",   32'(rx_bus.overrun_err), 32'h0);
        rst = 1'b0;
        wait_clks(4);

        // Stop mid-sample lands 155 clocks after the start bit at 16x:
        // 2 sync + 1 detect + 8 half-bit + 9 x 16 bit periods.
        $display("[TB] good frame 0xA5");
        apply_stimulus(8'hA5, 1'b1, -1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_output("a5_valid_early", 32'(valid_trace[154]), 32'h0);
        check_output("a5_valid_rise",  32'(valid_trace[155]), 32'h1);
        wait_clks(4);
        check_state("a5");

        $display("[TB] start-bit glitch");
        consume();
        rxd = 1'b0;
        wait_clks(3);
        rxd = 1'b1;
        wait_clks(40);
        check_state("glitch");

        $display("[TB] framing error 0x3C");
        apply_stimulus(8'h3C, 1'b0, -1, -1);
        model_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(4);
        check_state("ferr");

        $display("[TB] line break");
        apply_stimulus(8'h00, 1'b0, -1, -1);
        rxd = 1'b0;
        wait_clks(10 * OS);
        rxd = 1'b1;
        model_frame(8'h00, 1'b0, 1'b0);
        wait_clks(8);
        check_state("break");

        $display("[TB] overrun 0x11 then 0x22");
        apply_stimulus(8'h11, 1'b1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        wait_clks(4);
        check_state("ovr_first");
        apply_stimulus(8'h22, 1'b1, -1, -1);
        model_frame(8'h22, 1'b1, 1'b0);
        wait_clks(4);
        check_state("ovr_second");

        $display("[TB] ack on completion edge 0x7E");
        apply_stimulus(8'h7E, 1'b1, 154, -1);
        model_frame(8'h7E, 1'b1, 1'b1);
        wait_clks(4);
        check_state("simul_ack");

        $display("[TB] reset during bit 4 of 0xFF");
        apply_stimulus(8'hFF, 1'b1, -1, 85);
        exp_data  = '0;
        exp_valid = 1'b0;
        wait_clks(4);
        check_state("midrst");
        apply_stimulus(8'h81, 1'b1, -1, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        wait_clks(4);
        check_state("after_rst");

        $display("[TB] random frames");
        for (int i = 0; i < 12; i++) begin
            div   = int'($urandom_range(1, 2));
            rdata = DB'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) consume();
            wait_clks(3);
            apply_stimulus(rdata, rstop, -1, -1);
            model_frame(rdata, rstop, 1'b0);
            wait_clks(4);
            check_state($sformatf("rand%0d", i));
        end
        div = 1;
        wait_clks(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: sample_en ticks per bit period; legal values are even and at least 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 rxd  input  1  serial line, asynchronous to clk; idles high.
REQ-006 sample_en  input  1  one-clk oversample tick at OVERSAMPLE x baud, from the baud generator.
REQ-007 rx_ack  input  1  consumer accepts rx_data when sampled high while rx_valid=1.
REQ-008 rx_data  output  DATA_BITS  last good received byte.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun_err  output  1  one-clk pulse: a new byte overwrote an unconsumed byte.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized value rxs.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE->START SHALL occur when rxs=0 on any clk, independent of sample_en; the tick counter clears to 0 on entry.
REQ-015 Tick counter SHALL advance only on sample_en; the other states act only on sample_en.
REQ-016 START: when tick count reaches OVERSAMPLE/2-1, if rxs=1 -> IDLE (glitch reject, no output change); if rxs=0 -> DATA with tick count and bit index cleared.
REQ-017 DATA: every OVERSAMPLE ticks, rxs SHALL be shifted into the MSB of the shift register (right shift, LSB first); after DATA_BITS samples -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, rxs is sampled; the FSM returns to IDLE on the same edge, i.e. mid stop bit, which allows back-to-back frames.
REQ-019 Stop sample=1: rx_data <= shift register and rx_valid <= 1 on the same edge.
REQ-020 Stop sample=0: frame_err pulses for one clk; rx_data and rx_valid are unchanged.
REQ-021 rx_ack=1 while rx_valid=1 with no completion on that edge SHALL clear rx_valid on the next edge.
REQ-022 rx_ack=1 while rx_valid=0 SHALL be ignored.
REQ-023 Good completion while rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, and overrun_err pulses.
REQ-024 Good completion on the same edge as rx_ack=1: the new byte is loaded, rx_valid stays 1, and there is no overrun.
REQ-025 Line held low (break): the frame ends with frame_err, then the FSM re-enters START only after rxs is seen high in IDLE.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE.
REQ-027 rst=1 SHALL clear all counters and the shift register.
REQ-028 rst=1 SHALL force rx_data=0, rx_valid=0, frame_err=0 and overrun_err=0.
REQ-029 rst=1 SHALL set both synchronizer flops to 1.
REQ-030 rst asserted mid-frame SHALL abort the frame with no error pulse.

Structure
REQ-031 The FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, 2-bit) and the default OVERSAMPLE/DATA_BITS values SHALL live in shared package uart_pkg, which the tx block also uses.
REQ-032 The synchronizer SHALL be a separate sub-module named sync_2ff.
REQ-033 All other logic SHALL stay flat in uart_rx.

Verification
REQ-034 Good frame: drive 0xA5 at 16x with sample_en every clk -> rx_valid rises on the edge after the stop mid-sample, rx_data=0xA5, no error pulses.
REQ-035 Glitch: rxd low for 3 ticks then high -> FSM returns to IDLE, rx_valid stays 0, no frame_err.
REQ-036 Framing error: send 0x3C with the stop bit low -> one frame_err pulse, rx_data keeps its prior value, rx_valid unchanged.
REQ-037 Overrun: send 0x11 then 0x22 without rx_ack -> rx_data=0x22, one overrun_err pulse, rx_valid=1.
REQ-038 Simultaneous ack: assert rx_ack on the completion edge of 0x7E -> rx_data=0x7E, rx_valid=1, no overrun_err.
REQ-039 Reset mid-frame: pulse rst during bit 4 of 0xFF -> all outputs 0; the next 0x81 is received correctly.
